// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    WORD,
    CHK,
    DONE,
    ERR
  } state_e;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = WORD_BYTES * BYTE_W;
  localparam int unsigned CNT_W  = LEN_BYTES * BYTE_W;
  localparam int unsigned IDX_W  = $clog2(WORD_BYTES);

  localparam int unsigned        DEPTH_DEF     = 256;
  localparam logic [ADDR_W-1:0]  BASE_ADDR_DEF = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream (valid/ready) plus one-cycle instruction memory write port.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  // Loader side: consumes the stream, drives the memory write port.
  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  // Environment side: produces the stream, observes the memory write port.
  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into 32-bit words; pulses word_valid once per word.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              last_c,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int unsigned SHR_W = DATA_W - BYTE_W;

  logic [IDX_W-1:0] idx;
  logic [SHR_W-1:0] shreg;

  assign last_c = (idx == IDX_W'(WORD_BYTES - 1));

  // Byte index, lower-byte shift register and registered word output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx        <= '0;
      shreg      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        idx <= '0;
      end else if (byte_valid) begin
        idx <= idx + IDX_W'(1);
        if (last_c) begin
          word       <= {byte_data, shreg};
          word_valid <= 1'b1;
        end else begin
          shreg[int'(idx)*BYTE_W +: BYTE_W] <= byte_data;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction memory writes, holds core until done.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       DEPTH     = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_cnt
);

  state_e              state, state_next;
  logic [BYTE_W-1:0]   len_lo;
  logic [CNT_W-1:0]    len;
  logic [CNT_W-1:0]    len_in_c;
  logic                xfer;
  logic                launch;
  logic                byte_to_word;
  logic                last_c;
  logic                last_word_c;
  logic                word_valid;
  logic [DATA_W-1:0]   word;

  assign xfer         = bus.in_valid & bus.in_ready;
  assign len_in_c     = {bus.in_data, len_lo};
  assign launch       = start & (state inside {IDLE, DONE, ERR});
  assign byte_to_word = xfer & (state == WORD);
  assign last_word_c  = ((word_cnt + CNT_W'(1)) == len);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e AFTER_DATA = CHK;

  logic [BYTE_W-1:0] csum;
  logic              csum_ok_c;

  assign csum_ok_c = (bus.in_data == csum);

  // Running XOR over every accepted byte of the frame.
  always_ff @(posedge clk) begin
    if (!rst)        csum <= '0;
    else if (launch) csum <= '0;
    else if (xfer)   csum <= csum ^ bus.in_data;
  end
`else
  localparam state_e AFTER_DATA = DONE;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN0;
      LEN0:            if (xfer)  state_next = LEN1;
      LEN1: begin
        if (xfer) begin
          if (32'(len_in_c) > DEPTH)  state_next = ERR;
          else if (len_in_c == '0)    state_next = AFTER_DATA;
          else                        state_next = WORD;
        end
      end
      WORD: if (byte_to_word && last_c && last_word_c) state_next = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
      CHK:  if (xfer) state_next = csum_ok_c ? DONE : ERR;
`else
      CHK:  state_next = ERR;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.in_ready <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      bus.in_ready <= state_next inside {LEN0, LEN1, WORD, CHK};
      cpu_hold     <= (state_next != DONE);
      done         <= (state_next == DONE);
      error        <= (state_next == ERR);
    end
  end

  // Frame length capture, word counter and write address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_lo        <= '0;
      len           <= '0;
      word_cnt      <= '0;
      bus.imem_addr <= BASE_ADDR;
    end else if (launch) begin
      word_cnt      <= '0;
      bus.imem_addr <= BASE_ADDR;
    end else begin
      if (xfer && state == LEN0) len_lo <= bus.in_data;
      if (xfer && state == LEN1) len    <= len_in_c;
      if (byte_to_word && last_c) begin
        word_cnt      <= word_cnt + CNT_W'(1);
        bus.imem_addr <= BASE_ADDR + ADDR_W'(word_cnt) * ADDR_W'(WORD_BYTES);
      end
    end
  end

  assign bus.imem_we    = word_valid;
  assign bus.imem_wdata = word;

  imem_loader_word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clr        (launch),
    .byte_valid (byte_to_word),
    .byte_data  (bus.in_data),
    .last_c     (last_c),
    .word_valid (word_valid),
    .word       (word)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] cnt;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_cnt;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error),
    .word_cnt (word_cnt)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.imem_addr, e.addr);
        check("wr_data", bus.imem_wdata, e.data);
        check("wr_cnt", 32'(word_cnt), 32'(e.cnt));
      end
    end
  end

  function automatic bq_t build(input int unsigned n, input wq_t w);
    bq_t         f;
    logic [31:0] d;
    f.push_back(8'(n));
    f.push_back(8'(n >> 8));
    foreach (w[i]) begin
      d = w[i];
      for (int b = 0; b < 4; b++) f.push_back(d[b*8 +: 8]);
    end
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (f[i]) x = x ^ f[i];
      f.push_back(x);
    end
`endif
    return f;
  endfunction

  task automatic expect_words(input wq_t w);
    foreach (w[i]) begin
      wr_t e;
      e.addr = BASE + 32'(i) * 32'd4;
      e.data = w[i];
      e.cnt  = 16'(i + 1);
      exp_q.push_back(e);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input bit gap, input int start_at);
    for (int i = 0; i < f.size(); i++) begin
      if (i == start_at) start = 1'b1;
      send_byte(f[i]);
      start = 1'b0;
      if (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic h, input logic [15:0] c, input logic r);
    check({tag, ".done"},     32'(done),         32'(d));
    check({tag, ".error"},    32'(error),        32'(e));
    check({tag, ".cpu_hold"}, 32'(cpu_hold),     32'(h));
    check({tag, ".word_cnt"}, 32'(word_cnt),     32'(c));
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(r));
  endtask

  task automatic check_reset_values(input string tag);
    check_status(tag, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0);
    check({tag, ".imem_we"},    32'(bus.imem_we), 32'd0);
    check({tag, ".imem_addr"},  bus.imem_addr,    BASE);
    check({tag, ".imem_wdata"}, bus.imem_wdata,   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500us");
    $fatal(1, "timeout");
  end

  initial begin
    wq_t w2, wr, wbig, wnone;
    bq_t f;

    rst          = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    w2    = '{32'h0000_0013, 32'h0010_0093};
    wr    = '{32'hDEAD_BEEF, 32'h1234_5678};
    wnone = '{};
    for (int i = 0; i < int'(DEPTH); i++) wbig.push_back(32'hA500_0000 | 32'(i * 3));

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("idle");

    // Basic two-word image at full rate.
    expect_words(w2);
    pulse_start();
    check_status("started", 1'b0, 1'b0, 1'b1, 16'd0, 1'b1);
    send_frame(build(2, w2), 1'b0, -1);
    check_status("basic", 1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
    repeat (3) @(negedge clk);
    check("basic.no_extra", 32'(exp_q.size()), 32'd0);

    // Same image with in_valid low every other cycle.
    expect_words(w2);
    pulse_start();
    send_frame(build(2, w2), 1'b1, -1);
    check_status("gapped", 1'b1, 1'b0, 1'b0, 16'd2, 1'b0);

    // Oversize length: error right after LEN_HI, nothing written.
    pulse_start();
    f = '{8'h01, 8'h01};
    send_frame(f, 1'b0, -1);
    check_status("oversize", 1'b0, 1'b1, 1'b1, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_status("oversize_hold", 1'b0, 1'b1, 1'b1, 16'd0, 1'b0);

    // Empty image.
    pulse_start();
    send_frame(build(0, wnone), 1'b0, -1);
    check_status("empty", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: words land in memory, core stays held.
    expect_words(w2);
    pulse_start();
    f = build(2, w2);
    f[f.size()-1] = 8'h00;
    send_frame(f, 1'b0, -1);
    check_status("bad_chk", 1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
`endif

    // Reset after the third byte of word 1: no write, reset values.
    pulse_start();
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    send_frame(f, 1'b0, -1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_mid");
    rst = 1'b1;

    // Reset on the same edge as the final byte of a word cancels the write.
    pulse_start();
    send_frame(f, 1'b0, -1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    rst          = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    check_reset_values("rst_cancel");

    // Full load after reset, with a start pulse injected mid-frame.
    expect_words(w2);
    pulse_start();
    send_frame(build(2, w2), 1'b0, 5);
    check_status("mid_start", 1'b1, 1'b0, 1'b0, 16'd2, 1'b0);

    // Reload from DONE while LEN_LO is already offered: it must be taken only once.
    expect_words(wr);
    f = build(2, wr);
    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = f[0];
    @(negedge clk);
    start = 1'b0;
    check_status("reload", 1'b0, 1'b0, 1'b1, 16'd0, 1'b1);
    send_frame(f, 1'b0, -1);
    check_status("reload_done", 1'b1, 1'b0, 1'b0, 16'd2, 1'b0);

    // Largest accepted image.
    expect_words(wbig);
    pulse_start();
    send_frame(build(DEPTH, wbig), 1'b0, -1);
    check_status("full_depth", 1'b1, 1'b0, 1'b0, 16'(DEPTH), 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
